// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one imem request at a time
// and hands each returned word to decode; redirects flush in-flight work.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus4,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output state_t             fsm_state
);

  // Handshakes: imem_req rises for exactly one outstanding request and holds
  // imem_addr stable until the single-cycle imem_ack; id_valid holds the
  // id_* fields stable until a cycle with id_ready=1 (or a redirect drops it).

  state_t              state;
  logic                kill;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   redirect_aligned;

  assign redirect_aligned = redirect_pc & ~(ADDR_W'(3));
  assign fsm_state        = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
          if (redirect_valid) begin
            imem_addr <= redirect_aligned;
            pc        <= redirect_aligned;
          end else begin
            imem_addr <= pc;
          end
        end

        REQ: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            if (kill || redirect_valid) begin
              // Returning word belongs to a flushed path: drop it.
              kill  <= 1'b0;
              state <= IDLE;
              if (redirect_valid) pc <= redirect_aligned;
            end else begin
              id_instr    <= imem_rdata;
              id_pc       <= imem_addr;
              id_pc_plus4 <= imem_addr + PC_STEP;
              pc          <= imem_addr + PC_STEP;
              id_valid    <= 1'b1;
              state       <= HOLD;
            end
          end else if (redirect_valid) begin
            // Request cannot be withdrawn; remember to discard its data.
            pc   <= redirect_aligned;
            kill <= 1'b1;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            pc       <= redirect_aligned;
            id_valid <= 1'b0;
            state    <= IDLE;
          end else if (id_ready) begin
            id_valid <= 1'b0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a transaction-level model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        a_req, a_ack, a_valid, a_ready, a_rv;
  logic [31:0] a_addr, a_rdata, a_instr, a_pc, a_plus4, a_rpc;
  state_t      a_state;

  logic        w_req, w_ack, w_valid, w_ready, w_rv;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_plus4, w_rpc;
  state_t      w_state;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clock(clock), .reset(reset),
    .imem_req(a_req), .imem_addr(a_addr), .imem_ack(a_ack), .imem_rdata(a_rdata),
    .id_valid(a_valid), .id_ready(a_ready), .id_instr(a_instr), .id_pc(a_pc),
    .id_pc_plus4(a_plus4), .redirect_valid(a_rv), .redirect_pc(a_rpc),
    .fsm_state(a_state)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clock(clock), .reset(reset),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .id_valid(w_valid), .id_ready(w_ready), .id_instr(w_instr), .id_pc(w_pc),
    .id_pc_plus4(w_plus4), .redirect_valid(w_rv), .redirect_pc(w_rpc),
    .fsm_state(w_state)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'h5A17_C3E1;
  endfunction

  // Transaction-level model state: 0 = between requests, 1 = request
  // outstanding, 2 = instruction offered to decode.
  int          m_mode;
  logic [31:0] m_req_addr, m_next, m_show_pc, m_show_instr;
  bit          m_discard;
  logic [31:0] held_instr;

  initial begin
    a_ack = 0; a_rdata = 0; a_ready = 0; a_rv = 0; a_rpc = 0;
    w_ack = 0; w_rdata = 0; w_ready = 0; w_rv = 0; w_rpc = 0;

    // ---- reset values ----
    repeat (2) tick();
    check("rst_req", 32'(a_req), 0);
    check("rst_addr", a_addr, 0);
    check("rst_valid", 32'(a_valid), 0);
    check("rst_instr", a_instr, 0);
    check("rst_pc", a_pc, 0);
    check("rst_plus4", a_plus4, 0);
    check("rst_state", 32'(a_state), 32'(IDLE));
    check("rst_wrap_addr", w_addr, 0);

    // ---- basic fetch, ack two cycles into REQ ----
    reset = 0;
    tick();
    check("t1_req", 32'(a_req), 1);
    check("t1_addr", a_addr, 32'h0);
    tick();
    check("t1_wait_valid", 32'(a_valid), 0);
    a_ack = 1; a_rdata = 32'h2008_0005;
    tick();
    a_ack = 0; a_rdata = 0;
    check("t1_valid", 32'(a_valid), 1);
    check("t1_instr", a_instr, 32'h2008_0005);
    check("t1_pc", a_pc, 32'h0);
    check("t1_plus4", a_plus4, 32'h4);
    check("t1_req_drop", 32'(a_req), 0);
    a_ready = 1;
    tick();
    a_ready = 0;
    check("t1_accept_valid", 32'(a_valid), 0);
    check("t1_gap_req", 32'(a_req), 0);
    tick();
    check("t1_next_req", 32'(a_req), 1);
    check("t1_next_addr", a_addr, 32'h4);

    // ---- backpressure ----
    a_ack = 1; a_rdata = 32'h1111_2222;
    tick();
    a_ack = 0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(a_valid), 1);
      check("bp_instr", a_instr, 32'h1111_2222);
      check("bp_pc", a_pc, 32'h4);
      check("bp_req", 32'(a_req), 0);
      tick();
    end
    a_ready = 1;
    tick();
    a_ready = 0;
    check("bp_gap_valid", 32'(a_valid), 0);
    tick();
    check("bp_next_req", 32'(a_req), 1);
    check("bp_next_addr", a_addr, 32'h8);

    // ---- redirect in REQ before ack ----
    a_rv = 1; a_rpc = 32'h40;
    tick();
    a_rv = 0;
    check("rq_hold_req", 32'(a_req), 1);
    check("rq_hold_addr", a_addr, 32'h8);
    tick();
    a_ack = 1; a_rdata = 32'hDEAD_BEEF;
    tick();
    a_ack = 0;
    check("rq_discard_valid", 32'(a_valid), 0);
    check("rq_gap_req", 32'(a_req), 0);
    tick();
    check("rq_discard_valid2", 32'(a_valid), 0);
    check("rq_new_addr", a_addr, 32'h40);
    check("rq_new_req", 32'(a_req), 1);

    // ---- redirect coincident with ack ----
    a_ack = 1; a_rdata = 32'hBAD0_0001; a_rv = 1; a_rpc = 32'h103;
    tick();
    a_ack = 0; a_rv = 0;
    check("co_valid", 32'(a_valid), 0);
    tick();
    check("co_new_addr", a_addr, 32'h100);

    // ---- redirect in HOLD wins over id_ready ----
    a_ack = 1; a_rdata = 32'h0000_7777;
    tick();
    a_ack = 0;
    check("hd_valid", 32'(a_valid), 1);
    check("hd_pc", a_pc, 32'h100);
    a_rv = 1; a_rpc = 32'h1C7; a_ready = 1;
    tick();
    a_rv = 0; a_ready = 0;
    check("hd_drop_valid", 32'(a_valid), 0);
    tick();
    check("hd_new_addr", a_addr, 32'h1C4);
    check("hd_new_req", 32'(a_req), 1);

    // ---- asynchronous reset mid-REQ with ack during reset ----
    #2 reset = 1;
    #1;
    check("ar_req", 32'(a_req), 0);
    check("ar_addr", a_addr, 0);
    check("ar_instr", a_instr, 0);
    check("ar_pc", a_pc, 0);
    check("ar_plus4", a_plus4, 0);
    a_ack = 1; a_rdata = 32'hFFFF_0000;
    tick();
    check("ar_held_valid", 32'(a_valid), 0);
    reset = 0;
    tick();
    a_ack = 0; a_rdata = 0;
    check("ar_first_req", 32'(a_req), 1);
    check("ar_first_addr", a_addr, 32'h0);
    check("ar_ack_ignored", 32'(a_valid), 0);

    // ---- PC wrap on the second instance ----
    check("wr_addr", w_addr, 32'hFFFF_FFFC);
    w_ack = 1; w_rdata = 32'h0000_0013;
    tick();
    w_ack = 0;
    check("wr_pc", w_pc, 32'hFFFF_FFFC);
    check("wr_plus4", w_plus4, 32'h0);
    w_ready = 1;
    tick();
    w_ready = 0;
    tick();
    check("wr_next_req", 32'(w_req), 1);
    check("wr_next_addr", w_addr, 32'h0);

    // ---- randomized run against the model ----
    reset = 1;
    tick();
    reset = 0;
    m_mode = 0; m_next = 32'h0; m_discard = 0;
    m_req_addr = 0; m_show_pc = 0; m_show_instr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_req", 32'(a_req), 32'(m_mode == 1));
      check("rnd_valid", 32'(a_valid), 32'(m_mode == 2));
      if (m_mode == 1) check("rnd_addr", a_addr, m_req_addr);
      if (m_mode == 2) begin
        check("rnd_instr", a_instr, m_show_instr);
        check("rnd_pc", a_pc, m_show_pc);
        check("rnd_plus4", a_plus4, m_show_pc + 32'd4);
      end

      a_ack   = a_req && ($urandom_range(0, 2) == 0);
      a_rdata = a_ack ? mem_word(a_addr) : $urandom;
      a_ready = ($urandom_range(0, 1) == 1);
      a_rv    = ($urandom_range(0, 11) == 0);
      a_rpc   = (cyc % 97 == 5) ? 32'hFFFF_FFFF : $urandom;

      if (a_valid && a_ready && !a_rv) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $error("FAIL rnd_unexpected_delivery observed=%h expected=none", a_pc);
        end else begin
          check("rnd_stream_pc", a_pc, exp_q.pop_front());
        end
      end

      case (m_mode)
        0: begin
          m_req_addr = a_rv ? (a_rpc & ~32'd3) : m_next;
          m_next     = m_req_addr;
          m_discard  = 0;
          m_mode     = 1;
        end
        1: begin
          if (a_ack) begin
            if (m_discard || a_rv) begin
              if (a_rv) m_next = a_rpc & ~32'd3;
              m_discard = 0;
              m_mode    = 0;
            end else begin
              m_show_pc    = m_req_addr;
              m_show_instr = mem_word(m_req_addr);
              m_next       = m_req_addr + 32'd4;
              exp_q.push_back(m_req_addr);
              m_mode       = 2;
            end
          end else if (a_rv) begin
            m_next    = a_rpc & ~32'd3;
            m_discard = 1;
          end
        end
        default: begin
          if (a_rv) begin
            m_next = a_rpc & ~32'd3;
            void'(exp_q.pop_front());
            m_mode = 0;
          end else if (a_ready) begin
            m_mode = 0;
          end
        end
      endcase

      held_instr = a_instr;
      tick();
    end
    a_ack = 0; a_ready = 0; a_rv = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
